// File: rtl/transpose_ctrl_if.sv
// Handshake and status bundle between the transpose sequencer and its neighbours.
// Pure wiring: no logic, no latency.
// Backpressure is carried by row_ready (to the row DCT) and col_ready (from the column DCT).
interface transpose_ctrl_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(N);

  logic             abort;
  logic             row_valid;
  logic             row_ready;
  logic             col_valid;
  logic             col_ready;
  logic             tp_wr;
  logic             tp_rd;
  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] col_idx;
  logic             block_done;
  logic [CNT_W-1:0] blk_cnt;

  // Driver side: row DCT, column DCT and block-level control.
  modport master (
    output abort, row_valid, col_ready,
    input  row_ready, col_valid, tp_wr, tp_rd, row_idx, col_idx, block_done, blk_cnt
  );

  // Controller side.
  modport slave (
    input  abort, row_valid, col_ready,
    output row_ready, col_valid, tp_wr, tp_rd, row_idx, col_idx, block_done, blk_cnt
  );
endinterface

// File: rtl/transpose_ctrl.sv
// Fill/drain sequencer for the single-buffered NxN transpose memory between the DCT passes.
// Latency: strobes are combinational from state and handshakes; first column valid the cycle after the N-th row.
// Backpressure: row_valid gaps and col_ready gaps stall the row/column indices indefinitely.
module transpose_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  transpose_ctrl_if.slave    bus
);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic [IDX_W-1:0] col_idx_q, col_idx_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

  logic row_ready, col_valid, tp_wr, tp_rd, block_done;

  // Next-state and output decode; reset and abort both silence every strobe and handshake.
  always_comb begin
    state_d    = state_q;
    row_idx_d  = row_idx_q;
    col_idx_d  = col_idx_q;
    blk_cnt_d  = blk_cnt_q;
    row_ready  = 1'b0;
    col_valid  = 1'b0;
    tp_wr      = 1'b0;
    tp_rd      = 1'b0;
    block_done = 1'b0;
    if (rst) begin
      state_d = FILL;
    end else if (bus.abort) begin
      state_d   = FILL;
      row_idx_d = '0;
      col_idx_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          row_ready = 1'b1;
          tp_wr     = bus.row_valid;
          if (tp_wr) begin
            if (row_idx_q == LAST) begin
              row_idx_d = '0;
              state_d   = DRAIN;
            end else begin
              row_idx_d = row_idx_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          col_valid = 1'b1;
          tp_rd     = bus.col_ready;
          if (tp_rd) begin
            if (col_idx_q == LAST) begin
              // The final shift empties the array; the next fill rewrites every row.
              col_idx_d  = '0;
              block_done = 1'b1;
              blk_cnt_d  = blk_cnt_q + 1'b1;
              state_d    = FILL;
            end else begin
              col_idx_d = col_idx_q + 1'b1;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State, index and block counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      row_idx_q <= '0;
      col_idx_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign bus.row_ready  = row_ready;
  assign bus.col_valid  = col_valid;
  assign bus.tp_wr      = tp_wr;
  assign bus.tp_rd      = tp_rd;
  assign bus.block_done = block_done;
  assign bus.row_idx    = row_idx_q;
  assign bus.col_idx    = col_idx_q;
  assign bus.blk_cnt    = blk_cnt_q;
endmodule

// File: doc/transpose_ctrl.md
# transpose_ctrl

Sequencer for the 8x8 JPEG transpose memory between the row-pass and column-pass 1-D DCT stages. Accepts eight row words from the row DCT via a valid/ready handshake and issues the transpose write strobe for each. It then presents eight columns to the column DCT via a second valid/ready handshake and issues the transpose read (column-shift) strobe per accepted column. Single-buffered: a block is filled completely, then drained completely.

## Interface

Parameters:
- N, 8, rows per block = columns per block; index width is $clog2(N).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- abort  in  1  synchronous block abort; returns to FILL, clears indices.
- row_valid  in  1  row DCT has a 96-bit row on the transpose data input.
- row_ready  out  1  controller accepts a row this cycle.
- col_valid  out  1  transpose output currently holds a valid column.
- col_ready  in  1  column DCT consumes the presented column this cycle.
- tp_wr  out  1  transpose write strobe; loads the row and shifts the row chain.
- tp_rd  out  1  transpose read strobe; advances every row to the next column.
- row_idx  out  $clog2(N)  index of the next row to be written.
- col_idx  out  $clog2(N)  index of the column currently presented.
- block_done  out  1  one-cycle pulse when the last column of a block is accepted.
- blk_cnt  out  CNT_W  number of fully drained blocks since reset; wraps.

## Operation

- States: FILL (reset state) and DRAIN.
- FILL:
  - row_ready=1, col_valid=0.
  - tp_wr = row_valid & row_ready (combinational).
  - Each accepted row increments row_idx.
  - When the row with row_idx==N-1 is accepted: row_idx wraps to 0, next state DRAIN.
- DRAIN:
  - row_ready=0, col_valid=1.
  - tp_rd = col_valid & col_ready (combinational).
  - Column 0 is readable before any tp_rd; each tp_rd exposes the next column.
  - Each accepted column increments col_idx.
  - When the column with col_idx==N-1 is accepted: col_idx wraps to 0, block_done=1 in that cycle, blk_cnt increments at that edge, next state FILL.
  - The final tp_rd shifts out the last column. It is harmless because the next fill overwrites all N rows.
- Mutual exclusion: tp_wr and tp_rd are never high in the same cycle. The transpose treats wr&rd as hold, and the controller never generates it.
- row_valid during DRAIN is ignored: no tp_wr, and the upstream holds its data because row_ready=0.
- col_ready during FILL is ignored: no tp_rd.
- abort:
  - Priority is below rst and above all handshakes.
  - In the abort cycle: tp_wr=0, tp_rd=0, block_done=0, row_ready=0, col_valid=0.
  - At the clock edge: state goes to FILL and row_idx=col_idx=0. blk_cnt is unchanged.
  - Stale transpose contents need no clearing; N new writes replace them.
- rst:
  - While asserted, all strobes and handshake outputs are forced 0: tp_wr, tp_rd, row_ready, col_valid, block_done.
  - At the edge: state=FILL, row_idx=0, col_idx=0, blk_cnt=0.

## Timing

- Reset values: row_ready=0 while rst is high, 1 from the first cycle after rst deasserts. col_valid=0, tp_wr=0, tp_rd=0, block_done=0, row_idx=0, col_idx=0, blk_cnt=0.
- Strobes and ready/valid are decoded combinationally from registered state and the current handshake inputs. There is no strobe register stage.
- Latency: the N-th row is accepted at edge E; col_valid=1 in the cycle after E, with column 0 valid on the transpose output.
- The last column is accepted at edge E; row_ready=1 in the cycle after E.
- Peak throughput: 2N cycles per block (16 for N=8) with row_valid and col_ready held high.
- Gaps in row_valid or col_ready stall the index counters; there is no timeout.
- blk_cnt wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan

- Basic block:
  - Stimulus: reset, then 8 rows of row_valid=1 with col_ready=1.
  - Response: tp_wr high for exactly 8 cycles, then col_valid=1 one cycle later and tp_rd high for 8 cycles.
  - block_done pulses on the 8th tp_rd, blk_cnt=1, and row_ready=1 in the next cycle.
- Downstream backpressure:
  - Stimulus: during DRAIN, col_ready alternates 1,0; also hold it 0 for 5 cycles after column 3.
  - Response: tp_rd only when col_ready=1, col_idx frozen while stalled, and exactly 8 tp_rd per block.
- Upstream gaps and ignored inputs:
  - Stimulus: row_valid pattern 1,0,0,1,…; row_valid=1 during DRAIN; col_ready=1 during FILL.
  - Response: tp_wr count is 8 per block, with no tp_wr in DRAIN and no tp_rd in FILL.
- Back-to-back blocks:
  - Stimulus: 3 blocks at full rate.
  - Response: 48 cycles total, blk_cnt=3, and tp_wr/tp_rd never both high in any cycle.
- Abort:
  - Stimulus: pulse abort after column 4 of block 1.
  - Response: all strobes low in the abort cycle, FILL with row_idx=col_idx=0 next cycle, and blk_cnt unchanged (0).
  - The next full block then completes with blk_cnt=1.
- Counter wrap and reset mid-operation:
  - Stimulus: run with CNT_W=2 for 5 blocks; then assert rst after row 5 of a fill.
  - Response: blk_cnt reads 1,2,3,0,1. After rst, row_idx=0, blk_cnt=0 and state is FILL, and the block requires a full 8 new rows.
